// File: rtl/io_pkg.sv
// Shared definitions for the IO output-buffer write path: address window,
// store widths and the write-request record passed to the output buffer.
package io_pkg;

    localparam logic [19:0] IO_BASE_HI = 20'h10000;
    localparam logic [19:0] IO_LAST_HI = 20'h10004;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  funct3;
    } io_wr_t;

    // A store is legal when it targets the IO window with a supported,
    // naturally aligned width.
    function automatic logic io_legal(input logic [31:0] addr, input logic [2:0] funct3);
        logic in_range;
        logic aligned;
        in_range = (addr[31:12] >= IO_BASE_HI) && (addr[31:12] <= IO_LAST_HI);
        case (funct3)
            F3_SB:   aligned = 1'b1;
            F3_SH:   aligned = ~addr[0];
            F3_SW:   aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
        return in_range && aligned;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: the first set request at or after ptr
// (wrapping modulo N) wins. Shared by the write- and read-side arbiters.
module rr_pick #(
    parameter int N = 2,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    int  best_dist;
    int  sel;
    logic found;

    always_comb begin
        best_dist = N;
        sel       = 0;
        found     = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && (((i + N - int'(ptr)) % N) < best_dist)) begin
                best_dist = (i + N - int'(ptr)) % N;
                sel       = i;
                found     = 1'b1;
            end
        end
        grant = '0;
        for (int i = 0; i < N; i++) begin
            grant[i] = found && (i == sel);
        end
        idx = IW'(sel);
    end

endmodule

// File: rtl/io_wr_arbiter.sv
// Round-robin arbiter sharing the IO output-buffer write port; legal stores
// are issued from a registered stage, illegal ones are dropped and counted.
module io_wr_arbiter
    import io_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ERR_W   = 8,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_stall,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    output logic [NUM_REQ-1:0]        o_req_ready,
    input  logic [NUM_REQ-1:0][31:0]  i_req_addr,
    input  logic [NUM_REQ-1:0][31:0]  i_req_data,
    input  logic [NUM_REQ-1:0][2:0]   i_req_funct3,
    output logic [31:0]               o_io_addr,
    output logic [31:0]               o_st_data,
    output logic [2:0]                o_funct3,
    output logic                      o_io_wren,
    output logic [IW-1:0]             o_grant_id,
    output logic                      o_err_pulse,
    output logic [ERR_W-1:0]          o_err_count
);

    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    logic [IW-1:0]      ptr;
    logic [IW-1:0]      win_idx;
    logic [NUM_REQ-1:0] win_grant;
    logic               accept;
    logic               win_legal;
    io_wr_t             win_req;
    io_wr_t             out_q;
    logic [IW-1:0]      gid_q;
    logic               wren_q;
    logic               err_q;
    logic [ERR_W-1:0]   err_cnt_q;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req   (i_req_valid),
        .ptr   (ptr),
        .grant (win_grant),
        .idx   (win_idx)
    );

    // Ready is gated by reset too, so nothing is accepted in a reset cycle.
    assign o_req_ready = (i_reset && !i_stall) ? win_grant : '0;
    assign accept      = |(o_req_ready & i_req_valid);

    always_comb begin
        win_req.addr   = i_req_addr[win_idx];
        win_req.data   = i_req_data[win_idx];
        win_req.funct3 = i_req_funct3[win_idx];
        win_legal      = io_legal(win_req.addr, win_req.funct3);
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            ptr       <= '0;
            out_q     <= '0;
            gid_q     <= '0;
            wren_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            wren_q <= accept && win_legal;
            err_q  <= accept && !win_legal;
            if (accept) begin
                ptr <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            end
            if (accept && win_legal) begin
                out_q <= win_req;
                gid_q <= win_idx;
            end
            if (accept && !win_legal && (err_cnt_q != ERR_MAX)) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
        end
    end

    assign o_io_addr   = out_q.addr;
    assign o_st_data   = out_q.data;
    assign o_funct3    = out_q.funct3;
    assign o_io_wren   = wren_q;
    assign o_grant_id  = gid_q;
    assign o_err_pulse = err_q;
    assign o_err_count = err_cnt_q;

endmodule

// File: tb/tb_io_wr_arbiter.sv
// Self-checking bench for io_wr_arbiter: directed scenarios plus randomized
// traffic compared against a behavioural reference model.
module tb_io_wr_arbiter;

    localparam int N  = 2;
    localparam int EW = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 stall;
    logic [N-1:0]         valid;
    logic [N-1:0]         ready;
    logic [N-1:0][31:0]   addr;
    logic [N-1:0][31:0]   data;
    logic [N-1:0][2:0]    f3;
    logic [31:0]          o_io_addr;
    logic [31:0]          o_st_data;
    logic [2:0]           o_funct3;
    logic                 o_io_wren;
    logic                 o_grant_id;
    logic                 o_err_pulse;
    logic [EW-1:0]        o_err_count;

    int tests = 0;
    int fails = 0;

    // reference model state
    int            m_ptr;
    logic          m_wren, m_err, m_gid;
    logic [EW-1:0] m_cnt;
    logic [31:0]   m_addr, m_data;
    logic [2:0]    m_f3;

    io_wr_arbiter #(.NUM_REQ(N), .ERR_W(EW)) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_stall      (stall),
        .i_req_valid  (valid),
        .o_req_ready  (ready),
        .i_req_addr   (addr),
        .i_req_data   (data),
        .i_req_funct3 (f3),
        .o_io_addr    (o_io_addr),
        .o_st_data    (o_st_data),
        .o_funct3     (o_funct3),
        .o_io_wren    (o_io_wren),
        .o_grant_id   (o_grant_id),
        .o_err_pulse  (o_err_pulse),
        .o_err_count  (o_err_count)
    );

    always #5 clk = ~clk;

    function automatic logic ref_legal(input logic [31:0] a, input logic [2:0] w);
        int unsigned sz;
        if (w > 3'd2) return 1'b0;
        sz = 32'd1 << w;
        if (a < 32'h1000_0000 || a > 32'h1000_4FFF) return 1'b0;
        return (a % sz) == 0;
    endfunction

    function automatic int ref_winner();
        if (!rst_n || stall) return -1;
        for (int off = 0; off < N; off++) begin
            if (valid[(m_ptr + off) % N]) return (m_ptr + off) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] ref_ready();
        logic [N-1:0] r;
        int w;
        r = '0;
        w = ref_winner();
        if (w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    function automatic logic [101:0] exp_out();
        return {m_wren, m_err, m_cnt, m_gid, m_f3, m_addr, m_data};
    endfunction

    function automatic logic [101:0] act_out();
        return {o_io_wren, o_err_pulse, o_err_count, o_grant_id, o_funct3, o_io_addr, o_st_data};
    endfunction

    // Advance one clock edge and update the model with what that edge should do.
    task automatic tick();
        int w;
        w = ref_winner();
        @(posedge clk);
        if (!rst_n) begin
            m_ptr = 0; m_wren = 0; m_err = 0; m_cnt = '0; m_gid = 0;
            m_addr = '0; m_data = '0; m_f3 = '0;
        end else begin
            m_wren = 0;
            m_err  = 0;
            if (w >= 0) begin
                if (ref_legal(addr[w], f3[w])) begin
                    m_wren = 1; m_addr = addr[w]; m_data = data[w]; m_f3 = f3[w]; m_gid = 1'(w);
                end else begin
                    m_err = 1;
                    if (m_cnt != {EW{1'b1}}) m_cnt = m_cnt + 1'b1;
                end
                m_ptr = (w + 1) % N;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0; stall = 0; valid = '0;
        tick(); tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0; stall = 0; valid = 2'b11;
        addr[0] = 32'h1000_0000; data[0] = 32'h1111_1111; f3[0] = 3'b010;
        addr[1] = 32'h1000_0004; data[1] = 32'h2222_2222; f3[1] = 3'b010;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if (ready !== 2'b00) begin fails++; $display("FAIL reset_ready: got %b want 00", ready); end
            tick();
            tests++;
            if (act_out() !== 102'd0) begin fails++; $display("FAIL reset_outputs: got %h want 0", act_out()); end
        end
        rst_n = 1;
        #1;
        tests++;
        if (ready !== 2'b01) begin fails++; $display("FAIL reset_first_grant: got %b want 01", ready); end
        tick();
        tests++;
        if ({o_io_wren, o_grant_id, o_st_data} !== {1'b1, 1'b0, 32'h1111_1111}) begin
            fails++; $display("FAIL reset_first_issue: got wren=%b id=%0d data=%h want 1 0 11111111", o_io_wren, o_grant_id, o_st_data);
        end
    endtask

    task automatic test_fairness();
        do_reset();
        valid = 2'b11;
        addr[0] = 32'h1000_0000; data[0] = 32'hAAAA_0000; f3[0] = 3'b010;
        addr[1] = 32'h1000_0000; data[1] = 32'h5555_0001; f3[1] = 3'b010;
        for (int i = 0; i < 6; i++) begin
            #1;
            tests++;
            if (ready !== 2'(1 << (i % 2))) begin fails++; $display("FAIL fair_ready[%0d]: got %b want %b", i, ready, 2'(1 << (i % 2))); end
            tick();
            tests++;
            if ({o_io_wren, o_grant_id, o_st_data} !== {1'b1, 1'(i % 2), (i % 2) ? 32'h5555_0001 : 32'hAAAA_0000}) begin
                fails++; $display("FAIL fair_issue[%0d]: got wren=%b id=%0d data=%h", i, o_io_wren, o_grant_id, o_st_data);
            end
        end
        valid = '0;
    endtask

    task automatic test_single();
        do_reset();
        valid = 2'b10;
        addr[1] = 32'h1000_2003; data[1] = 32'h0000_00C3; f3[1] = 3'b000;
        #1;
        tests++;
        if (ready !== 2'b10) begin fails++; $display("FAIL single_ready: got %b want 10", ready); end
        tick();
        valid = '0;
        tests++;
        if ({o_io_wren, o_io_addr, o_funct3, o_grant_id, o_st_data} !== {1'b1, 32'h1000_2003, 3'b000, 1'b1, 32'h0000_00C3}) begin
            fails++; $display("FAIL single_issue: got wren=%b addr=%h f3=%b id=%0d data=%h", o_io_wren, o_io_addr, o_funct3, o_grant_id, o_st_data);
        end
        tick();
        tests++;
        if ({o_io_wren, o_io_addr, o_grant_id} !== {1'b0, 32'h1000_2003, 1'b1}) begin
            fails++; $display("FAIL single_hold: got wren=%b addr=%h id=%0d want 0 10002003 1", o_io_wren, o_io_addr, o_grant_id);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] bad_addr [3];
        logic [2:0]  bad_f3   [3];
        bad_addr[0] = 32'h1000_1002; bad_f3[0] = 3'b010;
        bad_addr[1] = 32'h2000_0000; bad_f3[1] = 3'b001;
        bad_addr[2] = 32'h1000_0000; bad_f3[2] = 3'b011;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            valid = 2'b01; addr[0] = bad_addr[i]; f3[0] = bad_f3[i]; data[0] = $urandom;
            #1;
            tests++;
            if (ready !== 2'b01) begin fails++; $display("FAIL illegal_ready[%0d]: got %b want 01", i, ready); end
            tick();
            tests++;
            if ({o_io_wren, o_err_pulse, o_err_count} !== {1'b0, 1'b1, 2'(i + 1)}) begin
                fails++; $display("FAIL illegal_drop[%0d]: got wren=%b err=%b cnt=%0d want 0 1 %0d", i, o_io_wren, o_err_pulse, o_err_count, i + 1);
            end
        end
        valid = '0;
        tick();
        tests++;
        if ({o_err_pulse, o_err_count} !== {1'b0, 2'd3}) begin
            fails++; $display("FAIL illegal_after: got err=%b cnt=%0d want 0 3", o_err_pulse, o_err_count);
        end
    endtask

    task automatic test_stall();
        do_reset();
        valid = 2'b11;
        addr[0] = 32'h1000_3000; data[0] = 32'hDEAD_0000; f3[0] = 3'b010;
        addr[1] = 32'h1000_3004; data[1] = 32'hBEEF_0001; f3[1] = 3'b010;
        #1;
        tick();
        stall = 1;
        #1;
        tests++;
        if ({ready, o_io_wren, o_grant_id} !== {2'b00, 1'b1, 1'b0}) begin
            fails++; $display("FAIL stall_drain: got ready=%b wren=%b id=%0d want 00 1 0", ready, o_io_wren, o_grant_id);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if (ready !== 2'b00) begin fails++; $display("FAIL stall_ready[%0d]: got %b want 00", i, ready); end
            tick();
            tests++;
            if (o_io_wren !== 1'b0) begin fails++; $display("FAIL stall_wren[%0d]: got %b want 0", i, o_io_wren); end
        end
        stall = 0;
        #1;
        tests++;
        if (ready !== 2'b10) begin fails++; $display("FAIL stall_resume: got %b want 10", ready); end
        tick();
        tests++;
        if ({o_io_wren, o_grant_id, o_st_data} !== {1'b1, 1'b1, 32'hBEEF_0001}) begin
            fails++; $display("FAIL stall_issue: got wren=%b id=%0d data=%h", o_io_wren, o_grant_id, o_st_data);
        end
        valid = '0;
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            valid = 2'b10; addr[1] = 32'h2000_0000 + $urandom_range(0, 255); f3[1] = 3'(i % 3);
            #1;
            tick();
            tests++;
            if ({o_io_wren, o_err_pulse, o_err_count} !== {1'b0, 1'b1, (i < 3) ? 2'(i + 1) : 2'd3}) begin
                fails++; $display("FAIL sat[%0d]: got wren=%b err=%b cnt=%0d", i, o_io_wren, o_err_pulse, o_err_count);
            end
        end
        valid = '0;
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 3))
            0, 1:    return 32'h1000_0000 + $urandom_range(0, 32'h4FFF);
            2:       return ($urandom_range(0, 1) ? 32'h1000_5000 : 32'h0FFF_F000) + $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 31) != 0);
            stall = ($urandom_range(0, 4) == 0);
            valid = N'($urandom);
            for (int k = 0; k < N; k++) begin
                addr[k] = rand_addr();
                data[k] = $urandom;
                f3[k]   = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
            end
            #1;
            tests++;
            if (ready !== ref_ready()) begin fails++; $display("FAIL rand_ready[%0d]: got %b want %b", i, ready, ref_ready()); end
            tick();
            tests++;
            if (act_out() !== exp_out()) begin fails++; $display("FAIL rand_out[%0d]: got %h want %h", i, act_out(), exp_out()); end
        end
        rst_n = 1; stall = 0; valid = '0;
    endtask

    initial begin
        rst_n = 0; stall = 0; valid = '0; addr = '0; data = '0; f3 = '0;
        test_reset();
        test_fairness();
        test_single();
        test_illegal();
        test_stall();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
